// File: rtl/dec_pkg.sv
// ============================================================================
// Module      : dec_pkg
// Description : Shared definitions for the registered N-to-2^N decoder:
//               default geometry, FSM state encoding and the one-hot helper.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents
//   c_dec_n_default     default select width
//   c_dec_dwell_default default sweep dwell (cycles per output)
//   c_dec_max_out_w     widest one-hot vector the helper can build (N <= 8)
//   dec_state_t         IDLE / SWEEP state encoding
//   dec_onehot()        index -> one-hot vector (caller truncates to width)
// ============================================================================
`default_nettype none

package dec_pkg;

    localparam int unsigned c_dec_n_default     = 3;
    localparam int unsigned c_dec_dwell_default = 4;
    localparam int unsigned c_dec_max_out_w     = 256;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } dec_state_t;

    // Returns a full-width one-hot vector; callers size-cast the result to
    // their own output width, so the helper works for any N up to 8.
    function automatic logic [c_dec_max_out_w-1:0] dec_onehot(input logic [7:0] idx);
        logic [c_dec_max_out_w-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_dwell_cnt.sv
// ============================================================================
// Module      : dec_dwell_cnt
// Description : Dwell / index counter used by the decoder auto-sweep. Each
//               index is held for DWELL counts, then the index advances.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N      index width
//   DWELL  counts per index (1..255)
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear of index and dwell counter (priority)
//   run         in   advance the dwell counter this cycle
//   idx         out  current sweep index
//   dwell_done  out  current index is in its final dwell count
//   last        out  final dwell count of the final index
// ============================================================================
`default_nettype none

module dec_dwell_cnt
    import dec_pkg::*;
#(
    parameter int unsigned N     = c_dec_n_default,
    parameter int unsigned DWELL = c_dec_dwell_default
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         run,
    output logic [N-1:0] idx,
    output logic         dwell_done,
    output logic         last
);

    localparam logic [7:0] c_dwell_max = 8'(DWELL - 1);

    logic [7:0]   r_dwell;
    logic [N-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            r_idx   <= '0;
        end else if (clr) begin
            r_dwell <= '0;
            r_idx   <= '0;
        end else if (run) begin
            if (dwell_done) begin
                r_dwell <= '0;
                r_idx   <= r_idx + 1'b1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign idx        = r_idx;
    assign dwell_done = (r_dwell == c_dwell_max);
    assign last       = dwell_done && (&r_idx);

endmodule

`default_nettype wire

// File: rtl/dec_nto2n_reg.sv
// ============================================================================
// Module      : dec_nto2n_reg
// Description : Registered N-to-2^N one-hot decoder with request handshake
//               and an optional auto-sweep that walks every output in turn,
//               holding each for DWELL cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option
//   DEC_SWEEP_EN  defined   : sweep FSM and dwell counter are built
//                 undefined : sweep_start ignored, sweep_busy tied low
// Parameters
//   N      select width (1..8); output width is 2^N
//   DWELL  cycles each output is held during a sweep (1..255)
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   block enable; low clears outputs and aborts a sweep
//   in_valid     in   decode request
//   in_sel       in   index to decode
//   in_ready     out  request can be accepted this cycle
//   sweep_start  in   one-cycle pulse starting an auto-sweep
//   sweep_busy   out  sweep in progress
//   out          out  registered one-hot (or all-zero) code
//   out_valid    out  out holds a valid one-hot code
// ============================================================================
`default_nettype none

module dec_nto2n_reg
    import dec_pkg::*;
#(
    parameter int unsigned N     = c_dec_n_default,
    parameter int unsigned DWELL = c_dec_dwell_default
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [N-1:0]    in_sel,
    output logic            in_ready,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic [2**N-1:0] out,
    output logic            out_valid
);

    localparam int unsigned c_out_w = 2**N;

    logic [c_out_w-1:0] r_out;
    logic               r_out_valid;
    logic [c_out_w-1:0] w_out_nxt;
    logic               w_out_valid_nxt;
    logic [c_out_w-1:0] w_sel_code;

    assign w_sel_code = c_out_w'(dec_onehot(8'(in_sel)));

`ifdef DEC_SWEEP_EN

    dec_state_t         r_state;
    dec_state_t         w_state_nxt;
    logic               w_cnt_clr;
    logic               w_cnt_run;
    logic [N-1:0]       w_idx;
    logic [N-1:0]       w_idx_inc;
    logic               w_dwell_done;
    logic               w_last;
    logic [c_out_w-1:0] w_idx_inc_code;

    dec_dwell_cnt #(
        .N     (N),
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_cnt_clr),
        .run        (w_cnt_run),
        .idx        (w_idx),
        .dwell_done (w_dwell_done),
        .last       (w_last)
    );

    assign w_idx_inc      = w_idx + 1'b1;
    assign w_idx_inc_code = c_out_w'(dec_onehot(8'(w_idx_inc)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        w_cnt_clr       = 1'b0;
        w_cnt_run       = 1'b0;

        if (!en) begin
            w_state_nxt     = ST_IDLE;
            w_out_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_cnt_clr       = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Counter stays parked at zero so a sweep starts cleanly.
                    w_cnt_clr = 1'b1;
                    // A decode request wins over a same-cycle sweep_start.
                    if (in_valid) begin
                        w_out_nxt       = w_sel_code;
                        w_out_valid_nxt = 1'b1;
                    end else if (sweep_start) begin
                        w_state_nxt     = ST_SWEEP;
                        w_out_nxt       = c_out_w'(1);
                        w_out_valid_nxt = 1'b1;
                    end
                end
                ST_SWEEP: begin
                    w_cnt_run = 1'b1;
                    if (w_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_out_nxt       = '0;
                        w_out_valid_nxt = 1'b0;
                    end else if (w_dwell_done) begin
                        // Output moves in step with the index increment.
                        w_out_nxt = w_idx_inc_code;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_out_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = en && (r_state == ST_IDLE);
    assign sweep_busy = (r_state == ST_SWEEP);

`else

    localparam int unsigned c_unused_dwell = DWELL;
    logic w_unused_sweep_start;
    assign w_unused_sweep_start = sweep_start;

    always_comb begin
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        if (!en) begin
            w_out_nxt       = '0;
            w_out_valid_nxt = 1'b0;
        end else if (in_valid) begin
            w_out_nxt       = w_sel_code;
            w_out_valid_nxt = 1'b1;
        end
    end

    assign in_ready   = en;
    assign sweep_busy = 1'b0;

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire
